// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared AER word layout constants and index-width helper
package aer_pkg;

  localparam int AER_W  = 24;
  localparam int CH_W   = 4;
  localparam int TS_W   = 20;
  localparam int CH_MSB = 23;
  localparam int CH_LSB = 20;
  localparam int TS_MSB = 19;
  localparam int TS_LSB = 0;

  // clog2(n), never less than 1 so a port index always has at least one bit
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational N-way round-robin picker starting at ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             any_win,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    any_win = 1'b0;
    grant   = '0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k modulo N; one subtraction suffices since ptr < N and k < N
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      idx = sum[IDX_W-1:0];
      if (!any_win && eligible[idx]) begin
        any_win      = 1'b1;
        grant[idx]   = 1'b1;
        win_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/aer_rr_arbiter.sv
// rtl/aer_rr_arbiter.sv - round-robin merge of N_REQ AER streams into one registered stream
module aer_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int AER_W = aer_pkg::AER_W,
  parameter int CNT_W = 16,
  localparam int IDX_W = aer_pkg::idx_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AER_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       port_en,
  output logic [AER_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_port,
  output logic [CNT_W-1:0]       evt_count
);

  logic             load_en;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic             any_win;
  logic [IDX_W-1:0] win_idx;
  logic [AER_W-1:0] words [N_REQ];

  logic [AER_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_port_q, out_port_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[i*AER_W +: AER_W];
  end

  assign eligible = req_valid & port_en;
  assign load_en  = !out_valid_q || out_ready;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any_win  (any_win),
    .grant    (grant),
    .win_idx  (win_idx)
  );

  // Gated by rst_n so no handshake completes while reset is asserted
  assign req_ready = (rst_n && load_en && any_win) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_port_d  = out_port_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (load_en) begin
      if (any_win) begin
        out_data_d  = words[win_idx];
        out_port_d  = win_idx;
        out_valid_d = 1'b1;
        ptr_d       = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (out_valid_q && out_ready && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_port_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_port_q  <= out_port_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_port  = out_port_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_aer_rr_arbiter.sv
// tb/tb_aer_rr_arbiter.sv - randomized and directed checks of aer_rr_arbiter against a queue-level model
module tb_aer_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_REQ=4, CNT_W=16
  logic [3:0]  a_req_valid, a_req_ready, a_port_en;
  logic [95:0] a_req_data;
  logic [23:0] a_out_data;
  logic        a_out_valid, a_out_ready;
  logic [1:0]  a_out_port;
  logic [15:0] a_evt_count;
  logic [23:0] a_src [4];
  assign a_req_data = {a_src[3], a_src[2], a_src[1], a_src[0]};

  // Instance B: N_REQ=3, CNT_W=4
  logic [2:0]  b_req_valid, b_req_ready, b_port_en;
  logic [71:0] b_req_data;
  logic [23:0] b_out_data;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_out_port;
  logic [3:0]  b_evt_count;
  logic [23:0] b_src [3];
  assign b_req_data = {b_src[2], b_src[1], b_src[0]};

  aer_rr_arbiter #(.N_REQ(4), .AER_W(24), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_ready(a_req_ready), .port_en(a_port_en), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_port(a_out_port),
    .evt_count(a_evt_count)
  );

  aer_rr_arbiter #(.N_REQ(3), .AER_W(24), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .port_en(b_port_en), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_port(b_out_port),
    .evt_count(b_evt_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model of instance A: a pending output slot plus a rotating turn counter
  int          m_ptr, m_port, m_cnt;
  bit          m_valid;
  logic [23:0] m_data;
  bit          reroll;
  int          sent [4];
  int          seen [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    int idx;
    if (m_valid && !a_out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (a_req_valid[idx] && a_port_en[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    int g;
    #1;
    g = model_pick();
    chk("a_req_ready", 32'(a_req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("a_out_valid", 32'(a_out_valid), 32'(m_valid));
    chk("a_out_data",  32'(a_out_data),  32'(m_data));
    chk("a_out_port",  32'(a_out_port),  32'(m_port));
    chk("a_evt_count", 32'(a_evt_count), 32'(m_cnt));
    if (a_out_valid && a_out_ready) seen[a_out_port]++;
    @(posedge clk);
    if (m_valid && a_out_ready && m_cnt != 32'hFFFF) m_cnt++;
    if (g >= 0) begin
      m_data  = a_src[g];
      m_port  = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % 4;
      sent[g]++;
    end else if (!m_valid || a_out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    if (reroll) begin
      for (int i = 0; i < 4; i++) begin
        if (g == i) begin
          a_src[i] = 24'($urandom);
          if ($urandom_range(3) == 0) a_req_valid[i] = 1'b0;
        end else if (!a_req_valid[i]) begin
          a_req_valid[i] = 1'($urandom_range(1));
        end
      end
    end
  endtask

  initial begin
    reroll = 1'b0;
    m_ptr = 0; m_port = 0; m_cnt = 0; m_valid = 1'b0; m_data = '0;
    for (int i = 0; i < 4; i++) begin sent[i] = 0; seen[i] = 0; end
    a_src[0] = 24'h100001; a_src[1] = 24'h200002; a_src[2] = 24'h300003; a_src[3] = 24'h400004;
    a_req_valid = 4'b1111; a_port_en = 4'b1111; a_out_ready = 1'b1;
    b_src[0] = 24'hA00010; b_src[1] = 24'hB00011; b_src[2] = 24'hC00012;
    b_req_valid = 3'b000; b_port_en = 3'b111; b_out_ready = 1'b1;

    // Reset held with all requesters valid
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data",  32'(a_out_data),  32'd0);
    chk("rst_a_out_port",  32'(a_out_port),  32'd0);
    chk("rst_a_evt_count", 32'(a_evt_count), 32'd0);
    chk("rst_b_evt_count", 32'(b_evt_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed distinct data, all ports valid: order 0,1,2,3,0,...
    tick();
    #1;
    chk("latency_valid", 32'(a_out_valid), 32'd1);
    chk("latency_port",  32'(a_out_port),  32'd0);
    repeat (8) tick();
    #1;
    chk("evt_after_8", 32'(a_evt_count), 32'd8);

    // Port 2 masked: order skips it
    a_port_en = 4'b1011;
    repeat (6) tick();

    // Backpressure for 5 cycles, then release with same-cycle regrant
    a_port_en = 4'b1111;
    a_out_ready = 1'b0;
    repeat (5) tick();
    a_out_ready = 1'b1;
    repeat (2) tick();

    // Randomized traffic, backpressure and enable mask
    reroll = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a_out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) a_port_en = 4'($urandom);
      tick();
    end

    // Drain and check every sent word arrived exactly once
    reroll = 1'b0;
    a_req_valid = 4'b0000;
    a_out_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("no_loss_port%0d", i), 32'(seen[i]), 32'(sent[i]));

    // Instance B: pointer wrap with N_REQ=3, then counter saturation
    b_req_valid = 3'b100;
    #1;
    chk("b_ready_p2", 32'(b_req_ready), 32'b100);
    tick();
    b_req_valid = 3'b101;
    #1;
    chk("b_port_2",  32'(b_out_port), 32'd2);
    chk("b_data_2",  32'(b_out_data), 32'hC00012);
    chk("b_wrap_p0", 32'(b_req_ready), 32'b001);
    tick();
    #1;
    chk("b_port_0",  32'(b_out_port), 32'd0);
    chk("b_data_0",  32'(b_out_data), 32'hA00010);
    chk("b_ready_2", 32'(b_req_ready), 32'b100);
    tick();
    #1;
    chk("b_port_2b", 32'(b_out_port), 32'd2);
    chk("b_ready_0", 32'(b_req_ready), 32'b001);
    chk("b_evt_2",   32'(b_evt_count), 32'd2);
    repeat (20) tick();
    #1;
    chk("b_evt_sat", 32'(b_evt_count), 32'd15);

    // Reset while a word is held discards it
    a_req_valid = 4'b1111;
    repeat (2) tick();
    #1;
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
    chk("mid_rst_count", 32'(a_evt_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aer_rr_arbiter.md
# aer_rr_arbiter

Round-robin arbiter that merges up to N_REQ independent AER event streams (4-bit channel, 20-bit timestamp) into the single AER word/valid stream consumed by the neural accelerator's AER input decoder. Each requester uses a valid/ready handshake. The merged output is registered and held under backpressure. A per-port enable mask and a saturating forwarded-event counter give the host basic configuration and observability.

## Interface
Parameters:
- N_REQ, 4: number of requesting AER sources, 2..16; need not be a power of two.
- AER_W, 24: AER word width, {channel[23:20], timestamp[19:0]}.
- CNT_W, 16: width of the forwarded-event counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-port event available.
- req_data  in  N_REQ*AER_W  per-port AER word; port i at bits [i*AER_W +: AER_W].
- req_ready  out  N_REQ  one-hot or zero; port i's word is consumed this cycle.
- port_en  in  N_REQ  port i eligible for grant only when 1.
- out_data  out  AER_W  merged AER word, to the decoder's `in`.
- out_valid  out  1  merged word valid, to the decoder's `aer_valid`.
- out_ready  in  1  downstream accepts; tie to 1 for the decoder (no backpressure).
- out_port  out  clog2(N_REQ)  index of the port that produced out_data.
- evt_count  out  CNT_W  number of words accepted downstream, saturating.

## Operation
- A transfer on port i occurs when req_valid[i] && req_ready[i].
- Output transfer occurs when out_valid && out_ready.
- load_en = !out_valid || out_ready. This means the output register is empty or is being drained this cycle.
- eligible[i] = req_valid[i] && port_en[i].
- Round-robin pointer ptr is in 0..N_REQ-1. The winner is the first eligible index scanning ptr, ptr+1, ... and wrapping from N_REQ-1 to 0.
- req_ready[w] = 1 combinationally only when load_en is 1 and some port is eligible. All other bits are 0.
- On a transfer from port w:
  - out_data <= req_data[w]
  - out_port <= w
  - out_valid <= 1
  - ptr <= (w == N_REQ-1) ? 0 : w+1
- When load_en is 1 and no port is eligible: out_valid <= 0. out_data and out_port hold their last values.
- When load_en is 0: out_data, out_port, out_valid and ptr all hold. req_ready is all-zero.
- On every output transfer, evt_count increments by 1 and saturates at all-ones.
- The payload passes through unmodified; the arbiter does no channel remap and no timestamp check.
- port_en is sampled combinationally each cycle.
  - Clearing a port's bit stops future grants to it.
  - A word from that port already in the output register is still delivered.
- A requester must hold req_valid and req_data stable until its transfer.
- The arbiter never drops or duplicates a word.

## Timing
- Reset (async assert, synchronous deassert handled upstream) sets:
  - out_valid=0, out_data=0, out_port=0, ptr=0, evt_count=0.
  - req_ready=0 while rst_n is low.
- Reset mid-transfer discards the held output word. Any requester handshake pending in that cycle does not complete.
- Latency: req_valid to out_valid is 1 cycle (grant in cycle t, out_valid high in t+1).
- Throughput is 1 word per cycle when out_ready=1.
- With out_ready=0 and out_valid=1, req_ready stays 0 and everything holds.
- In the cycle out_ready rises, a new grant issues in the same cycle as the drain (no bubble).
- Fairness: with all ports continuously eligible and out_ready=1, the grant order is 0,1,...,N_REQ-1,0,... Any eligible port waits at most N_REQ-1 grants.
- A single eligible port is granted every cycle.
- Simultaneous requests never produce more than one req_ready bit.
- The combinational path from out_ready and req_valid to req_ready is allowed. There is no path from out_ready to out_data.

## Structure
- Shared package aer_pkg holds:
  - AER_W=24, CH_W=4, TS_W=20.
  - Field slice constants CH_MSB=23, CH_LSB=20, TS_MSB=19, TS_LSB=0.
  - Helper for clog2(N_REQ), floored at 1.
- One sub-module, rr_pick: a purely combinational N-way round-robin priority picker.
  - Inputs: eligible vector and ptr.
  - Outputs: any_win, one-hot grant, and the encoded winner index.
- All state (output register, ptr, evt_count) lives in aer_rr_arbiter.

## Test plan
- Reset with req_valid=4'b1111 held: all outputs 0, req_ready=0. First grant after release goes to port 0, and out_valid rises on the next cycle.
- Ports 0..3 continuously valid with distinct data (0x1_00001, 0x2_00002, 0x3_00003, 0x4_00004), out_ready=1: outputs in order port 0,1,2,3,0,... at one per cycle; evt_count=8 after 8 words.
- port_en=4'b1011 with all ports valid: port 2 never granted; order 0,1,3,0,1,3.
- With out_valid=1, drop out_ready to 0 for 5 cycles: out_data and out_port stable, req_ready=0, evt_count unchanged. On release, the held word is accepted and the next grant issues in the same cycle.
- N_REQ=3, only port 2 valid, then ports 0 and 2 valid: pointer wraps 2→0 and port 0 wins next. Scoreboard confirms no word is lost or duplicated.
- CNT_W=4 with 20 words forwarded: evt_count saturates at 15.
